core_sequencer: RTL and testbench

//   Parametrised program-flow sequencer for the 9-bit-ISA core: owns the PC, run/halt

---
 rtl/core_sequencer.sv | 115 +++++++++++
 tb/tb_core_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// -----------------------------------------------------------------------------
// core_sequencer
//   Program-flow sequencer for the 9-bit-ISA core. Owns the program counter,
//   the IDLE/RUN/HALT state and a saturating retired-instruction counter.
//   It drives the instruction ROM address and reacts to start, stall, halt
//   and branch requests from the decoder, ALU and data memory.
//
// Parameters
//   PC_W        PC / instruction-address width
//   CNT_W       retired-instruction counter width
//   REL_BRANCH  1: branch_rel honoured, 0: every branch is absolute
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst_n        synchronous active-low reset
//   start        1-cycle pulse: load start_addr, clear the counter, enter RUN
//   start_addr   first instruction address, sampled with start
//   stall        hold PC and counter this cycle
//   branch       taken branch/jump for the current instruction
//   branch_rel   1: target is a signed offset from pc, 0: absolute address
//   target       branch target or two's-complement offset
//   halt_req     current instruction is HALT
//   pc           current instruction address
//   running      registered, 1 while in RUN
//   halted       registered, 1 while in HALT
//   instr_count  instructions retired since the last start
//   count_sat    sticky, set when the counter reaches all-ones
// -----------------------------------------------------------------------------
module core_sequencer #(
  parameter int PC_W       = 10,
  parameter int CNT_W      = 16,
  parameter bit REL_BRANCH = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PC_W-1:0]  start_addr,
  input  logic             stall,
  input  logic             branch,
  input  logic             branch_rel,
  input  logic [PC_W-1:0]  target,
  input  logic             halt_req,
  output logic [PC_W-1:0]  pc,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count,
  output logic             count_sat
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [PC_W-1:0]  pc_next;
  logic [CNT_W-1:0] count_next;
  logic             sat_next;
  logic             use_rel;

  // Relative mode only exists when the parameter enables it.
  assign use_rel = REL_BRANCH && branch_rel;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_next = state;
    pc_next    = pc;
    count_next = instr_count;
    sat_next   = count_sat;

    if (start) begin
      state_next = ST_RUN;
      pc_next    = start_addr;
      count_next = '0;
      sat_next   = 1'b0;
    end else if (state == ST_RUN && !stall) begin
      // The instruction retires: count it unless already saturated.
      if (!count_sat) begin
        count_next = instr_count + 1'b1;
        if (&count_next) sat_next = 1'b1;
      end
      if (halt_req) begin
        state_next = ST_HALT;             // pc stays on the HALT address
      end else if (branch) begin
        // Same-width add is the sign-extended sum modulo 2^PC_W.
        pc_next = use_rel ? pc + target : target;
      end else begin
        pc_next = pc + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // values from before the edge, regardless of statement order.
    if (!rst_n) begin
      state       <= ST_IDLE;
      pc          <= '0;
      instr_count <= '0;
      count_sat   <= 1'b0;
      running     <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      instr_count <= count_next;
      count_sat   <= sat_next;
      running     <= (state_next == ST_RUN);
      halted      <= (state_next == ST_HALT);
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// -----------------------------------------------------------------------------
// tb_core_sequencer
//   Directed bench for core_sequencer. Three instances share one stimulus:
//   the default build, an absolute-only build (REL_BRANCH=0) and a 4-bit
//   counter build (CNT_W=4). Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_core_sequencer;

  localparam int PC_W = 10;

  logic            clk = 1'b0;
  logic            rst_n, start, stall, branch, branch_rel, halt_req;
  logic [PC_W-1:0] start_addr, target;

  logic [PC_W-1:0] pc_a, pc_b, pc_c;
  logic            run_a, run_b, run_c, hlt_a, hlt_b, hlt_c;
  logic [15:0]     cnt_a, cnt_b;
  logic [3:0]      cnt_c;
  logic            sat_a, sat_b, sat_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  core_sequencer #(.PC_W(PC_W), .CNT_W(16), .REL_BRANCH(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .stall(stall), .branch(branch), .branch_rel(branch_rel), .target(target),
    .halt_req(halt_req), .pc(pc_a), .running(run_a), .halted(hlt_a),
    .instr_count(cnt_a), .count_sat(sat_a)
  );

  core_sequencer #(.PC_W(PC_W), .CNT_W(16), .REL_BRANCH(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .stall(stall), .branch(branch), .branch_rel(branch_rel), .target(target),
    .halt_req(halt_req), .pc(pc_b), .running(run_b), .halted(hlt_b),
    .instr_count(cnt_b), .count_sat(sat_b)
  );

  core_sequencer #(.PC_W(PC_W), .CNT_W(4), .REL_BRANCH(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .stall(stall), .branch(branch), .branch_rel(branch_rel), .target(target),
    .halt_req(halt_req), .pc(pc_c), .running(run_c), .halted(hlt_c),
    .instr_count(cnt_c), .count_sat(sat_c)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; sample and re-drive 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [PC_W-1:0] addr);
    start      = 1'b1;
    start_addr = addr;
    step();
    start      = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; branch = 1'b0;
    branch_rel = 1'b0; halt_req = 1'b0; start_addr = '0; target = '0;
    step(); step();

    // Reset state
    check("rst_pc", pc_a, 0);
    check("rst_running", run_a, 0);
    check("rst_halted", hlt_a, 0);
    check("rst_count", cnt_a, 0);
    check("rst_sat", sat_a, 0);

    // 1: start at 0x005 then sequential fetch
    rst_n = 1'b1;
    step();
    check("idle_running", run_a, 0);
    do_start(10'h005);
    check("start_pc", pc_a, 10'h005);
    check("start_running", run_a, 1);
    check("start_count", cnt_a, 0);
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("seq_pc%0d", i), pc_a, 10'h005 + i);
    end
    check("seq_count", cnt_a, 4);

    // 2: relative and absolute branches
    do_start(10'h010);
    branch = 1'b1; branch_rel = 1'b1; target = 10'h3FE;
    step();
    check("rel_pc", pc_a, 10'h00E);
    check("rel_pc_absonly", pc_b, 10'h3FE);
    check("rel_count", cnt_a, 1);
    branch_rel = 1'b0; target = 10'h123;
    step();
    check("abs_pc", pc_a, 10'h123);
    check("abs_pc_absonly", pc_b, 10'h123);

    // 3: stall blocks branch and halt
    stall = 1'b1; halt_req = 1'b1; target = 10'h200;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", pc_a, 10'h123);
      check("stall_count", cnt_a, 2);
      check("stall_running", run_a, 1);
    end
    stall = 1'b0; halt_req = 1'b0; branch = 1'b0;
    step();
    check("unstall_pc", pc_a, 10'h124);
    check("unstall_count", cnt_a, 3);

    // 4: halt at 0x020, HALT ignores branch, restart from halt
    do_start(10'h020);
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    check("halt_halted", hlt_a, 1);
    check("halt_running", run_a, 0);
    check("halt_pc", pc_a, 10'h020);
    check("halt_count", cnt_a, 1);
    branch = 1'b1; target = 10'h155;
    step();
    branch = 1'b0;
    check("halt_hold_pc", pc_a, 10'h020);
    check("halt_hold_count", cnt_a, 1);
    do_start(10'h000);
    check("restart_running", run_a, 1);
    check("restart_halted", hlt_a, 0);
    check("restart_pc", pc_a, 0);
    check("restart_count", cnt_a, 0);

    // 5: 4-bit counter saturation
    for (int i = 1; i <= 20; i++) begin
      step();
      check($sformatf("sat_cnt%0d", i), cnt_c, (i >= 15) ? 15 : i);
      check($sformatf("sat_flag%0d", i), sat_c, (i >= 15) ? 1 : 0);
    end
    check("wide_count", cnt_a, 20);
    check("wide_sat", sat_a, 0);
    do_start(10'h000);
    check("sat_clr_cnt", cnt_c, 0);
    check("sat_clr_flag", sat_c, 0);

    // 6: pc wrap, restart during RUN, reset beats start
    do_start(10'h3FE);
    step();
    check("wrap_pc_3ff", pc_a, 10'h3FF);
    step();
    check("wrap_pc_000", pc_a, 10'h000);
    check("wrap_count", cnt_a, 2);
    branch = 1'b1; target = 10'h1AA;
    do_start(10'h050);
    branch = 1'b0;
    check("rerun_pc", pc_a, 10'h050);
    check("rerun_count", cnt_a, 0);
    step();
    rst_n = 1'b0; start = 1'b1; start_addr = 10'h077;
    step();
    start = 1'b0;
    check("midrst_pc", pc_a, 0);
    check("midrst_running", run_a, 0);
    check("midrst_halted", hlt_a, 0);
    check("midrst_count", cnt_a, 0);
    check("midrst_sat", sat_a, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
